// File: rtl/rcos_seq_ctrl.sv
// Sequencer for the time-shared raised-cosine FIR: buffers input samples, paces
// filter strobes, captures latency-matched results and runs zero-stuffing flushes.
module rcos_seq_ctrl #(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned OSIZE   = 19,
  parameter int unsigned SLOT    = 8,
  parameter int unsigned LAT     = 8,
  parameter int unsigned FDEPTH  = 4,
  parameter int unsigned FLUSH_N = 9
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  output logic             s_ready,
  input  logic             flush,
  output logic             busy,
  output logic             f_din_en,
  output logic [DSIZE-1:0] f_din,
  input  logic [OSIZE-1:0] f_dout,
  output logic             m_valid,
  output logic [OSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic             ovf_err,
  input  logic             clr_err
);

  localparam int unsigned AW   = $clog2(FDEPTH);
  localparam int unsigned FW   = AW + 1;
  localparam int unsigned CNTW = 8;
  localparam int unsigned FLW  = $clog2(FLUSH_N + 1);
  localparam int unsigned WTW  = $clog2(LAT + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] mem_q [FDEPTH];
  logic [DSIZE-1:0] mem_d [FDEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNTW-1:0]  slot_q, slot_d;
  logic [FLW-1:0]   flush_left_q, flush_left_d;
  logic [WTW-1:0]   wait_q, wait_d;
  logic [LAT-1:0]   tag_stb_q, tag_stb_d;
  logic [LAT-1:0]   tag_real_q, tag_real_d;
  logic             f_din_en_q, f_din_en_d;
  logic [DSIZE-1:0] f_din_q, f_din_d;
  logic             m_valid_q, m_valid_d;
  logic [OSIZE-1:0] m_data_q, m_data_d;
  logic             ovf_q, ovf_d;

  logic fifo_full, fifo_empty;
  logic push, pop, fl_issue, issue, capture;

  assign fifo_full  = (fill_q == FW'(FDEPTH));
  assign fifo_empty = (fill_q == '0);
  assign s_ready    = !fifo_full && (state_q != ST_FLUSH);
  assign busy       = !fifo_empty || (|tag_stb_q) || (state_q == ST_FLUSH);

  assign push     = s_valid && s_ready;
  assign pop      = (state_q == ST_RUN) && !flush && (slot_q == '0) && !fifo_empty;
  assign fl_issue = (state_q == ST_FLUSH) && (flush_left_q != '0) && (slot_q == '0);
  assign issue    = pop || fl_issue;
  // Oldest tag lines up with the filter result becoming valid on f_dout.
  assign capture  = tag_real_q[LAT-1];

  assign f_din_en = f_din_en_q;
  assign f_din    = f_din_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign ovf_err  = ovf_q;

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q + FW'(push) - FW'(pop);
    slot_d       = slot_q;
    flush_left_d = flush_left_q;
    wait_d       = wait_q;
    tag_stb_d    = {tag_stb_q[LAT-2:0], issue};
    tag_real_d   = {tag_real_q[LAT-2:0], pop};
    f_din_en_d   = issue;
    f_din_d      = pop ? mem_q[rd_ptr_q] : '0;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    ovf_d        = ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Slot pacing: reload on every strobe, count down and rest at zero.
    if (issue) begin
      slot_d = CNTW'(SLOT - 1);
    end else if (slot_q != '0) begin
      slot_d = slot_q - CNTW'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d      = ST_FLUSH;
          flush_left_d = FLW'(FLUSH_N);
          wait_d       = '0;
        end
      end
      ST_FLUSH: begin
        if (fl_issue) begin
          flush_left_d = flush_left_q - FLW'(1);
          if (flush_left_q == FLW'(1)) begin
            wait_d = WTW'(LAT);
          end
        end else if (flush_left_q == '0) begin
          if (wait_q <= WTW'(1)) begin
            state_d = ST_RUN;
            wait_d  = '0;
          end else begin
            wait_d = wait_q - WTW'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Output register: a capture into a stalled register is dropped and flagged.
    if (clr_err) begin
      ovf_d = 1'b0;
    end
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (capture) begin
      if (m_valid_q && !m_ready) begin
        ovf_d = 1'b1;
      end else begin
        m_valid_d = 1'b1;
        m_data_d  = f_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_RUN;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      slot_q       <= '0;
      flush_left_q <= '0;
      wait_q       <= '0;
      tag_stb_q    <= '0;
      tag_real_q   <= '0;
      f_din_en_q   <= 1'b0;
      f_din_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      slot_q       <= slot_d;
      flush_left_q <= flush_left_d;
      wait_q       <= wait_d;
      tag_stb_q    <= tag_stb_d;
      tag_real_q   <= tag_real_d;
      f_din_en_q   <= f_din_en_d;
      f_din_q      <= f_din_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rcos_seq_ctrl.sv
// Scoreboard bench for rcos_seq_ctrl with a behavioural 9-tap raised-cosine filter
// standing in for the rcosine_03 datapath.
module tb_rcos_seq_ctrl;

  localparam int unsigned DSIZE   = 8;
  localparam int unsigned OSIZE   = 19;
  localparam int unsigned SLOT    = 8;
  localparam int unsigned LAT     = 8;
  localparam int unsigned FDEPTH  = 4;
  localparam int unsigned FLUSH_N = 9;
  localparam int H [9] = '{38, 54, 68, 80, 81, 80, 68, 54, 38};

  logic             clk     = 1'b0;
  logic             n_rst   = 1'b0;
  logic             s_valid = 1'b0;
  logic [DSIZE-1:0] s_data  = '0;
  logic             s_ready;
  logic             flush   = 1'b0;
  logic             busy;
  logic             f_din_en;
  logic [DSIZE-1:0] f_din;
  logic [OSIZE-1:0] f_dout;
  logic             m_valid;
  logic [OSIZE-1:0] m_data;
  logic             m_ready = 1'b0;
  logic             ovf_err;
  logic             clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [OSIZE-1:0] exp_q [$];
  int stb_cyc [$];
  int stb_val [$];

  rcos_seq_ctrl #(
    .DSIZE(DSIZE), .OSIZE(OSIZE), .SLOT(SLOT), .LAT(LAT), .FDEPTH(FDEPTH), .FLUSH_N(FLUSH_N)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .busy(busy),
    .f_din_en(f_din_en), .f_din(f_din), .f_dout(f_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .ovf_err(ovf_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter model: result of a strobe in cycle T is on f_dout during cycle T+LAT-1.
  logic [DSIZE-1:0] dl [9] = '{default: '0};
  logic [OSIZE-1:0] fpipe [LAT-1] = '{default: '0};
  int acc;

  always_comb begin
    acc = H[0] * int'(f_din);
    for (int k = 1; k < 9; k++) acc += H[k] * int'(dl[k-1]);
  end

  always @(posedge clk) begin
    if (f_din_en) begin
      dl[0] <= f_din;
      for (int k = 1; k < 9; k++) dl[k] <= dl[k-1];
    end
    fpipe[0] <= f_din_en ? OSIZE'(acc) : fpipe[0];
    for (int k = 1; k < LAT - 1; k++) fpipe[k] <= fpipe[k-1];
  end

  assign f_dout = fpipe[LAT-2];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard on every output handshake, and a log of filter strobes.
  always @(negedge clk) begin
    logic [OSIZE-1:0] exp_v;
    if (n_rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: actual %0d required no result (cycle %0d)", m_data, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        chk("result", longint'(m_data), longint'(exp_v));
      end
    end
    if (n_rst && f_din_en) begin
      stb_cyc.push_back(cyc);
      stb_val.push_back(int'(f_din));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DSIZE-1:0] v, output int c);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (!s_ready) chk("push_timeout", 0, 1);
    c = cyc;
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit with_m);
    int t;
    t = 0;
    tick(1);
    while ((busy || (with_m && m_valid)) && t < 400) begin
      tick(1);
      t++;
    end
    if (busy || (with_m && m_valid)) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_flush();
    int base, nz;
    base  = stb_cyc.size();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_idle(1'b1);
    chk("flush_strobe_count", stb_cyc.size() - base, FLUSH_N);
    nz = 0;
    for (int i = base; i < stb_val.size(); i++) if (stb_val[i] != 0) nz++;
    chk("flush_nonzero_din", nz, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c2, base, first_low, resume, idx, rise, t;

    // T1: reset values, then a reset in the middle of traffic
    tick(3);
    chk("rst_f_din_en", f_din_en, 0);
    chk("rst_f_din", f_din, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_ovf_err", ovf_err, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    n_rst = 1'b1;
    tick(2);
    push(8'd7, c);
    push(8'd8, c);
    push(8'd9, c);
    tick(2);
    chk("pre_rst_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_f_din_en", f_din_en, 0);
    chk("mid_rst_f_din", f_din, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_ovf_err", ovf_err, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_busy", busy, 0);
    tick(1);
    n_rst   = 1'b1;
    m_ready = 1'b1;
    tick(25);
    chk("post_rst_no_m_valid", m_valid, 0);
    chk("post_rst_busy", busy, 0);

    // T2: impulse response after a clean flush
    do_flush();
    base = stb_cyc.size();
    for (int i = 0; i < 9; i++) exp_q.push_back(OSIZE'(H[i]));
    push(8'd1, c);
    for (int i = 1; i < 9; i++) push(8'd0, c);
    wait_idle(1'b1);
    chk("imp_strobe_count", stb_cyc.size() - base, 9);
    if (stb_cyc.size() >= base + 9) begin
      chk("imp_first_din", stb_val[base], 1);
      for (int i = 1; i < 9; i++) chk("imp_spacing", stb_cyc[base+i] - stb_cyc[base+i-1], SLOT);
    end

    // T3: single-sample latency (history holds only the trailing impulse, now shifted out)
    exp_q.push_back(19'd190);
    push(8'd5, c);
    chk("lat_busy", busy, 1);
    t = 0;
    while (!m_valid && t < 50) begin
      tick(1);
      t++;
    end
    rise = cyc;
    chk("lat_pop_to_valid", rise - (c + 1), LAT + 1);
    wait_idle(1'b1);

    // T3: six back-to-back samples against a 4-deep FIFO
    exp_q.push_back(19'd650);
    exp_q.push_back(19'd1298);
    exp_q.push_back(19'd2130);
    exp_q.push_back(19'd3095);
    exp_q.push_back(19'd4140);
    exp_q.push_back(19'd5201);
    idx       = 0;
    first_low = -1;
    resume    = -1;
    s_valid   = 1'b1;
    s_data    = 8'd10;
    for (int k = 0; k < 60 && idx < 6; k++) begin
      if (s_ready) begin
        if (first_low >= 0 && resume < 0) resume = k;
        idx++;
      end else if (first_low < 0) begin
        first_low = k;
      end
      tick(1);
      if (idx < 6) s_data = DSIZE'(10 + idx);
    end
    s_valid = 1'b0;
    chk("bp_accepted", idx, 6);
    chk("bp_first_not_ready", first_low, 5);
    chk("bp_resume_after_pop", resume, 10);
    wait_idle(1'b1);

    // T4: overflow while the output is stalled, then clear the sticky flag
    do_flush();
    m_ready = 1'b0;
    push(8'd20, c);
    push(8'd21, c);
    wait_idle(1'b0);
    chk("ovf_m_valid", m_valid, 1);
    chk("ovf_m_data_kept", m_data, 760);
    chk("ovf_err_set", ovf_err, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("ovf_err_cleared", ovf_err, 0);
    chk("ovf_m_valid_held", m_valid, 1);
    exp_q.push_back(19'd760);
    m_ready = 1'b1;
    wait_idle(1'b1);

    // T5: flush with two samples queued and one in flight; second flush pulse ignored
    do_flush();
    exp_q.push_back(19'd1140);
    exp_q.push_back(19'd1178);
    exp_q.push_back(19'd2890);
    push(8'd30, c);
    push(8'd31, c);
    push(8'd32, c);
    base  = stb_cyc.size();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    chk("flush_s_ready", s_ready, 0);
    chk("flush_busy", busy, 1);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_idle(1'b1);
    chk("mid_flush_strobes", stb_cyc.size() - base, FLUSH_N + 2);
    if (stb_cyc.size() >= base + FLUSH_N + 2) begin
      idx = 0;
      for (int i = 0; i < FLUSH_N; i++) if (stb_val[base+i] != 0) idx++;
      chk("mid_flush_zero_din", idx, 0);
      chk("mid_flush_resume_b", stb_val[base+FLUSH_N], 31);
      chk("mid_flush_resume_c", stb_val[base+FLUSH_N+1], 32);
    end

    // T6: downstream accept coinciding with a new capture
    do_flush();
    m_ready = 1'b0;
    exp_q.push_back(19'd1520);
    exp_q.push_back(19'd3718);
    push(8'd40, c);
    push(8'd41, c2);
    tick(15);
    chk("coinc_pre_m_valid", m_valid, 1);
    chk("coinc_pre_m_data", m_data, 1520);
    m_ready = 1'b1;
    tick(1);
    chk("coinc_m_valid_stays", m_valid, 1);
    chk("coinc_m_data_new", m_data, 3718);
    chk("coinc_no_ovf", ovf_err, 0);
    wait_idle(1'b1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
